// File: rtl/muldiv_div_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU. It stalls the pipeline while iterating
// and returns one registered result; divide-by-zero and signed overflow complete without iterating.
module muldiv_div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [3:0]      m_con_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] quo, rem, dvs, result;
  logic [CW-1:0]   count;
  logic [1:0]      op;
  logic            sign_q, sign_r;

  logic            accept, signed_in, signed_op, div_zero, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_result, q_fix, r_fix;
  logic [XLEN:0]   rem_wide, trial;
  logic            fits;

  assign accept    = start_i && (m_con_i[3:2] == 2'b10) && (state == IDLE) && !flush_i;
  assign signed_in = ~m_con_i[0];
  assign signed_op = ~op[0];

  assign stall_o  = accept || (state == CALC) || (state == FIX);
  assign busy_o   = (state != IDLE);
  assign done_o   = (state == DONE);
  assign result_o = result;

  // Operand magnitudes and the cases resolved without iterating.
  always_comb begin
    a_mag    = (signed_in && op_a_i[XLEN-1]) ? -op_a_i : op_a_i;
    b_mag    = (signed_in && op_b_i[XLEN-1]) ? -op_b_i : op_b_i;
    div_zero = (op_b_i == '0);
    ovf      = signed_in && (op_a_i == MIN_NEG) && (op_b_i == '1);
    special  = div_zero || ovf;
    if (div_zero) special_result = m_con_i[1] ? op_a_i : '1;
    else          special_result = m_con_i[1] ? '0 : MIN_NEG;
  end

  // One extra bit on the partial remainder keeps the compare/subtract exact for unsigned divisors.
  always_comb begin
    rem_wide = {rem, quo[XLEN-1]};
    trial    = rem_wide - {1'b0, dvs};
    fits     = ~trial[XLEN];
    q_fix    = (signed_op && sign_q) ? -quo : quo;
    r_fix    = (signed_op && sign_r) ? -rem : rem;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: begin
        if (flush_i)          state_next = IDLE;
        else if (count == '0) state_next = FIX;
      end
      FIX:  state_next = flush_i ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      result <= '0;
      count  <= '0;
      op     <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            op     <= m_con_i[1:0];
            sign_q <= op_a_i[XLEN-1] ^ op_b_i[XLEN-1];
            sign_r <= op_a_i[XLEN-1];
            quo    <= a_mag;
            dvs    <= b_mag;
            rem    <= '0;
            count  <= CW'(XLEN-1);
            if (special) result <= special_result;
          end
        end
        CALC: begin
          if (!flush_i) begin
            rem <= fits ? trial[XLEN-1:0] : rem_wide[XLEN-1:0];
            quo <= {quo[XLEN-2:0], fits};
            if (count != '0) count <= count - 1'b1;
          end
        end
        FIX: begin
          if (!flush_i) result <= op[1] ? r_fix : q_fix;
        end
        default: ;
      endcase
    end
  end

endmodule
